// File: rtl/reload_down_timer_if.sv
// Control/status bundle for reload_down_timer: the master programs and qualifies
// the count, the slave (the timer) reports its count, busy, tc and done.
interface reload_down_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             auto_reload;
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tc;
  logic             done;

  // Handshake: load is a single-edge request with no ready; it is sampled on
  // every rising clk and always accepted, overriding any counting that edge.
  modport master (
    output load, din, auto_reload, enable,
    input  count, busy, tc, done
  );

  modport slave (
    input  load, din, auto_reload, enable,
    output count, busy, tc, done
  );
endinterface

// File: rtl/reload_down_timer.sv
// Loadable down-counter with one-shot and auto-reload modes; emits a one-cycle
// registered tc pulse when the count expires, plus a sticky one-shot done flag.
module reload_down_timer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  reload_down_timer_if.slave   bus,
  output logic                 dbg_state
);
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_val;
  logic             mode;
  logic             busy_q;
  logic             tc_q;
  logic             done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count_q    <= ZERO;
      reload_val <= ZERO;
      mode       <= 1'b0;
      busy_q     <= 1'b0;
      tc_q       <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.load) begin
      // A zero load parks the timer idle without ever signalling expiry.
      count_q    <= bus.din;
      reload_val <= bus.din;
      mode       <= bus.auto_reload;
      done_q     <= 1'b0;
      tc_q       <= 1'b0;
      if (bus.din != ZERO) begin
        state  <= RUN;
        busy_q <= 1'b1;
      end else begin
        state  <= IDLE;
        busy_q <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          tc_q <= 1'b0;
        end
        RUN: begin
          if (!bus.enable) begin
            tc_q <= 1'b0;
          end else if (count_q == ONE) begin
            // Terminal edge: redirect instead of decrementing through zero.
            tc_q <= 1'b1;
            if (mode) begin
              count_q <= reload_val;
            end else begin
              count_q <= ZERO;
              state   <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            count_q <= count_q - ONE;
            tc_q    <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          tc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_reload_down_timer.sv
// Directed bench for reload_down_timer: a table of {inputs, expected outputs}
// records plus hand-written sequences for reset, latency and periodicity.
module tb_reload_down_timer;
  localparam int W = 4;

  logic clk;
  logic rst;
  logic dbg_state;

  reload_down_timer_if #(.WIDTH(W)) bus ();

  reload_down_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         load;
    logic [W-1:0] din;
    logic         auto_rl;
    logic         en;
    logic [W-1:0] cnt;
    logic         busy;
    logic         tc;
    logic         done;
  } vec_t;

  vec_t           vecs[$];
  logic [W+2:0]   exp_q[$];
  int             n_vec = 0;
  int             n_bad = 0;

  function automatic void add(input logic ld, input int d, input logic ar, input logic en,
                              input int c, input logic b, input logic t, input logic dn);
    vec_t v;
    v.load = ld; v.din = W'(d); v.auto_rl = ar; v.en = en;
    v.cnt = W'(c); v.busy = b; v.tc = t; v.done = dn;
    vecs.push_back(v);
  endfunction

  // driver tasks
  task automatic drive(input logic ld, input logic [W-1:0] d, input logic ar, input logic en);
    bus.load = ld; bus.din = d; bus.auto_reload = ar; bus.enable = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: expected {count, busy, tc, done} queued, then compared
  task automatic check(input string name);
    logic [W+2:0] exp, act;
    exp = exp_q.pop_front();
    act = {bus.count, bus.busy, bus.tc, bus.done};
    n_vec++;
    if (act !== exp || dbg_state !== bus.busy) begin
      n_bad++;
      $display("FAIL %s: got count=%0d busy=%0b tc=%0b done=%0b state=%0b, want count=%0d busy=%0b tc=%0b done=%0b",
               name, act[W+2:3], act[2], act[1], act[0], dbg_state,
               exp[W+2:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic expect_out(input string name, input int c, input logic b, input logic t, input logic dn);
    exp_q.push_back({W'(c), b, t, dn});
    check(name);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    int consec;
    logic prev_tc;

    // ---- table: one-shot din=5
    add(1, 5, 0, 1,  5, 1, 0, 0);
    add(0, 0, 0, 1,  4, 1, 0, 0);
    add(0, 0, 0, 1,  3, 1, 0, 0);
    add(0, 0, 0, 1,  2, 1, 0, 0);
    add(0, 0, 0, 1,  1, 1, 0, 0);
    add(0, 0, 0, 1,  0, 0, 1, 1);
    add(0, 0, 0, 1,  0, 0, 0, 1);
    add(0, 0, 0, 1,  0, 0, 0, 1);
    // auto-reload din=3, enable 1,0,1,1,0,1
    add(1, 3, 1, 0,  3, 1, 0, 0);
    add(0, 0, 0, 1,  2, 1, 0, 0);
    add(0, 0, 0, 0,  2, 1, 0, 0);
    add(0, 0, 0, 1,  1, 1, 0, 0);
    add(0, 0, 0, 1,  3, 1, 1, 0);
    add(0, 0, 0, 0,  3, 1, 0, 0);
    add(0, 0, 0, 1,  2, 1, 0, 0);
    // load zero from RUN parks idle, enable ignored
    add(1, 0, 1, 1,  0, 0, 0, 0);
    add(0, 0, 0, 1,  0, 0, 0, 0);
    // one-shot din=15: 15 enabled edges to tc, no wrap
    add(1, 15, 0, 1, 15, 1, 0, 0);
    for (int i = 14; i >= 1; i--) add(0, 0, 0, 1, i, 1, 0, 0);
    add(0, 0, 0, 1,  0, 0, 1, 1);
    add(0, 0, 0, 1,  0, 0, 0, 1);
    // auto din=1: tc every enabled cycle
    add(1, 1, 1, 1,  1, 1, 0, 0);
    add(0, 0, 0, 1,  1, 1, 1, 0);
    add(0, 0, 0, 1,  1, 1, 1, 0);
    add(0, 0, 0, 1,  1, 1, 1, 0);
    add(0, 0, 0, 0,  1, 1, 0, 0);
    // load din=9 on the terminal edge of a one-shot
    add(1, 2, 0, 1,  2, 1, 0, 0);
    add(0, 0, 0, 1,  1, 1, 0, 0);
    add(1, 9, 0, 1,  9, 1, 0, 0);
    add(0, 0, 0, 1,  8, 1, 0, 0);
    // restart at 2 from count 6
    add(1, 7, 0, 1,  7, 1, 0, 0);
    add(0, 0, 0, 1,  6, 1, 0, 0);
    add(1, 2, 0, 1,  2, 1, 0, 0);
    add(0, 0, 0, 1,  1, 1, 0, 0);
    add(0, 0, 0, 1,  0, 0, 1, 1);
    // auto_reload changed mid-run is not captured
    add(1, 3, 0, 1,  3, 1, 0, 0);
    add(0, 0, 1, 1,  2, 1, 0, 0);
    add(0, 0, 1, 1,  1, 1, 0, 0);
    add(0, 0, 1, 1,  0, 0, 1, 1);
    add(0, 0, 1, 1,  0, 0, 0, 1);

    // ---- reset
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset_state", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table loop
    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].din, vecs[i].auto_rl, vecs[i].en);
      tick();
      exp_q.push_back({vecs[i].cnt, vecs[i].busy, vecs[i].tc, vecs[i].done});
      check($sformatf("vec%0d", i));
    end

    // ---- async reset mid-run at count=7
    drive(1'b1, W'(7), 1'b1, 1'b0);
    tick();
    expect_out("run_at_7", 7, 1, 0, 0);
    drive(1'b0, '0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    expect_out("async_reset_before_edge", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    expect_out("idle_after_reset", 0, 0, 0, 0);

    // ---- one-shot latency: tc exactly N=6 edges after the load edge
    drive(1'b1, W'(6), 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      cyc++;
      if (bus.tc) break;
    end
    check_val("oneshot_latency_n6", bus.tc ? cyc : -1, 6);

    // ---- auto-reload period 4 over 12 enabled edges
    drive(1'b1, W'(4), 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    pulses = 0;
    consec = 0;
    prev_tc = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.tc) pulses++;
      if (bus.tc && prev_tc) consec++;
      prev_tc = bus.tc;
    end
    check_val("auto_period4_pulses", pulses, 3);
    check_val("auto_period4_no_back_to_back", consec, 0);
    check_val("auto_period4_done_low", int'(bus.done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reload_down_timer.md
# reload_down_timer

Loadable down-counter/timer that consumes a programmed count value and reports its expiry. It is the complement of the team's loadable up-counter: it counts a loaded value down to zero instead of counting up from it. It emits a single-cycle terminal-count pulse, and supports one-shot and auto-reload modes. It sits next to control FSMs that need programmable delays or periodic ticks.

## Interface
- WIDTH, default 4, width of din/count and of the internal reload register
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state immediately
- load  input  1  load request, sampled on rising clk; priority over all other activity
- din  input  WIDTH  start/reload value, captured when load=1
- auto_reload  input  1  mode select, captured together with din when load=1 (1 = periodic, 0 = one-shot)
- enable  input  1  count-down qualifier in RUN; 0 = hold
- count  output  WIDTH  current counter value (registered)
- busy  output  1  1 while in RUN state (registered)
- tc  output  1  terminal-count pulse, exactly one cycle wide (registered)
- done  output  1  sticky one-shot expiry flag; cleared by load or rst

## Operation
- Internal registers: count, reload_val (WIDTH), mode (1 bit), state {IDLE, RUN}, tc, done.
- Reset (async, rst=1): count=0, reload_val=0, mode=0, state=IDLE, busy=0, tc=0, done=0. Outputs hold these while rst=1.
- Load (load=1 at edge, any state): count<=din, reload_val<=din, mode<=auto_reload, done<=0, tc<=0.
  - If din!=0, next state is RUN.
  - If din==0, next state is IDLE. No tc, no done.
- IDLE, load=0: all registers hold. enable is ignored. tc=0.
- RUN, load=0, enable=0: count holds, tc<=0.
- RUN, load=0, enable=1, count>1: count<=count-1, tc<=0.
- RUN, load=0, enable=1, count==1 (terminal edge): tc<=1.
  - mode=0: count<=0, state<=IDLE, done<=1.
  - mode=1: count<=reload_val, state stays RUN, done unchanged (0).
- Arithmetic: modulo-2^WIDTH decrement never underflows, because the count==1 edge always redirects. count never decrements from 0.
- Auto-reload period: tc pulses once every reload_val enabled cycles. With reload_val=1, tc is high on every enabled cycle.
- Simultaneous events:
  - load together with a terminal edge: load wins, tc<=0, done<=0.
  - load of a new value in RUN restarts the count with no tc.
- Reset during RUN aborts immediately. No tc is emitted.

## Timing
- Load latency 1 cycle: count=din and busy=1 in the cycle after the load edge.
- Decrement latency 1 cycle per enabled edge.
- tc is registered and high for the single cycle following the terminal edge. In that cycle count shows 0 (one-shot) or reload_val (auto-reload).
- One-shot: busy falls and done rises in the same cycle that tc is high.
- One-shot from load of N with enable held 1: tc high exactly N cycles after the load edge's cycle.
- tc is never high for two consecutive cycles unless mode=1, reload_val=1 and enable stays 1.
- No combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst mid-run with count=7 -> count=0, busy=0, tc=0, done=0 asynchronously, before the next clk edge.
- One-shot: WIDTH=4, load din=5, auto_reload=0, enable=1 -> count 5,4,3,2,1,0; tc single pulse with count=0; busy 1->0 and done=1 in that cycle; stays idle afterwards.
- Auto-reload with gaps: load din=3, auto_reload=1, enable toggled 1,0,1,1,0,1 -> count holds on enable=0; tc after every 3rd enabled edge with count back at 3; busy stays 1; done stays 0.
- Boundaries:
  - load din=0 -> busy=0, tc=0, done=0.
  - load din=15 -> 15 enabled cycles to tc, no wrap past 0.
  - auto din=1, enable=1 -> tc high every cycle.
- Collisions:
  - load din=9 on the terminal edge of a one-shot -> count=9, busy=1, tc=0, done=0.
  - load din=2 in RUN at count=6 -> restart at 2, tc after 2 enabled cycles.
- Mode capture: change auto_reload while in RUN after loading with 0 -> behaviour stays one-shot until the next load.
